grayscale_frame_sequencer: RTL
==============================

# grayscale_frame_sequencer

Frame-level controller for the RGB-to-grayscale converter stage. On a start pulse it scans a source frame buffer in raster order, feeds the converter one pixel per cycle and tracks its pipeline latency. It writes each grayscale result to the destination buffer at the matching address, then signals frame completion. It sits between the RGB frame memory (synchronous read, 1-cycle latency), the `rgb_to_grayscale` converter (1-cycle latency) and the grayscale frame memory.

## Interface
- `IMG_W`, 256: frame width in pixels (≥1).
- `IMG_H`, 256: frame height in lines (≥1).
- `ADDR_W`, 16: address width. Requires 2^ADDR_W ≥ IMG_W*IMG_H.
- `clk`  in  1  clock.
- `rst`  in  1  reset. Synchronous, active-high. Clock is `clk`.
- `start_i`  in  1  frame start request. Sampled only in IDLE.
- `abort_i`  in  1  synchronous abort. Return to IDLE, no completion pulse.
- `rd_en_o`  out  1  source memory read enable.
- `rd_addr_o`  out  ADDR_W  source read address, linear raster index.
- `rd_rgb_i`  in  24  source read data {R[23:16], G[15:8], B[7:0]}. Valid 1 cycle after `rd_en_o`.
- `red_o`, `green_o`, `blue_o`  out  8 each  converter pixel inputs.
- `conv_valid_o`  out  1  converter `done_i` strobe.
- `gray_i`  in  8  converter grayscale output.
- `gray_valid_i`  in  1  converter `done_o`.
- `wr_en_o`  out  1  destination memory write enable.
- `wr_addr_o`  out  ADDR_W  destination write address.
- `wr_data_o`  out  8  destination write data.
- `busy_o`  out  1  high from the first read cycle through the last write cycle.
- `frame_done_o`  out  1  one-cycle pulse after the last write.

## Operation
- N = IMG_W*IMG_H (localparam). Read counter `rd_cnt` and write counter `wr_cnt` are both ADDR_W wide.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: outputs quiet. On `start_i`, go to RUN and clear both counters.
  - RUN: `rd_en_o`=1, `rd_addr_o`=`rd_cnt`, and `rd_cnt` increments every cycle. The cycle issuing address N-1 transitions to DRAIN. No stalls; one read per cycle.
  - DRAIN: no reads. Wait until `wr_cnt` reaches N, then go to DONE.
  - DONE: `frame_done_o`=1 for exactly one cycle, then IDLE.
- `red_o`/`green_o`/`blue_o` are driven combinationally from `rd_rgb_i`. `conv_valid_o` is `rd_en_o` delayed one cycle.
- Write path is registered:
  - On `gray_valid_i` while in RUN or DRAIN: `wr_en_o`<=1, `wr_data_o`<=`gray_i`, `wr_addr_o`<=`wr_cnt`, then `wr_cnt`++.
  - Otherwise `wr_en_o`<=0. `wr_data_o`/`wr_addr_o` hold their values.
- `gray_valid_i` in IDLE or DONE is ignored (no write, no count).
- `start_i` outside IDLE is ignored. `start_i` in the DONE cycle is ignored.
- `abort_i` takes priority over every transition. It forces IDLE and zeros the counters and the valid delay line. The write in flight at the abort edge is suppressed. Later `gray_valid_i` pulses from the converter drain are ignored because the FSM is in IDLE.
- `rst` has the same effect as `abort_i`, and additionally clears `wr_addr_o`/`wr_data_o`.
- Reset values: all outputs 0; state IDLE.
- Counter wrap: `rd_cnt` never exceeds N-1. Under the parameter constraint, `wr_cnt` reaches N without overflowing ADDR_W, or reaches exactly 2^ADDR_W only if N = 2^ADDR_W. In that case the completion compare uses a dedicated terminal flag, not `wr_cnt`==N.

## Timing
- `start_i` sampled at edge k:
  - Reads at addr 0..N-1 in cycles k+1..k+N.
  - `conv_valid_o` in k+2..k+N+1.
  - `gray_valid_i` in k+3..k+N+2.
  - `wr_en_o` in k+4..k+N+3.
  - `frame_done_o` in k+N+4.
- Read-to-write latency is a fixed 3 cycles.
- `busy_o` is high k+1..k+N+3 and low during the `frame_done_o` cycle.
- Back-to-back frames: earliest next `start_i` is sampled on the edge after the DONE cycle. Frame period is N+5 cycles.
- N=1: single read at k+1, write at k+4, done at k+5.

## Structure
- Shared package `grayscale_pkg` holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - the pixel packing constants (R/G/B bit offsets, 8-bit channel width);
  - the datapath latency constants `SRC_RD_LAT`=1 and `CONV_LAT`=1, used to size the delay line.
- One sub-module: `valid_delay_line`. Parameterised depth, shift register with synchronous clear, used for `rd_en_o`→`conv_valid_o`.
- The converter itself is instantiated by the parent, not inside this block.

## Test plan
- IMG_W=4, IMG_H=2, source pixel i = {8'(i*30), 8'(i*20), 8'(i*10)}, start at edge 0:
  - reads addr 0..7 in cycles 1..8;
  - writes addr 0..7 in cycles 4..11, data matching the converter model;
  - `frame_done_o` only in cycle 12.
- `start_i` held high continuously: second frame's first read in cycle 14. No read or write in cycle 12 or 13.
- `abort_i` in cycle 6 of the above frame: reads stop, `wr_en_o` is 0 from cycle 7 on, `frame_done_o` never asserts, `busy_o` is 0 in cycle 7. A following `start_i` restarts at addr 0.
- `rst` asserted in DRAIN (cycle 10): all outputs 0 next cycle; late `gray_valid_i` pulses produce no writes.
- Spurious `gray_valid_i` in IDLE: no `wr_en_o`, and `wr_cnt` is still 0 at the next frame's first write.
- IMG_W=1, IMG_H=1: one read at cycle 1, one write at addr 0 in cycle 4, `frame_done_o` in cycle 5.

Source files
------------

// File: rtl/grayscale_pkg.sv
// Shared types and constants for the grayscale frame sequencer slice:
// FSM states, RGB pixel packing and datapath latencies.
package grayscale_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam int CH_W  = 8;
  localparam int PIX_W = 3 * CH_W;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  // Source memory read latency and converter latency, in cycles.
  localparam int SRC_RD_LAT = 1;
  localparam int CONV_LAT   = 1;

  function automatic logic [CH_W-1:0] get_channel(input logic [PIX_W-1:0] pix, input int lsb);
    return pix[lsb +: CH_W];
  endfunction

endpackage

// File: rtl/grayscale_frame_sequencer_valid_delay_line.sv
// Fixed-depth shift register for a single valid strobe, with a synchronous
// clear that empties every stage at once.
module valid_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_sr;

  // Shift the strobe one stage per cycle; clear drops anything in flight.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/grayscale_frame_sequencer.sv
// Frame-level sequencer: streams a source RGB frame through the external
// grayscale converter and writes each result to the destination buffer.
module grayscale_frame_sequencer
  import grayscale_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [PIX_W-1:0]  rd_rgb_i,
  output logic [CH_W-1:0]   red_o,
  output logic [CH_W-1:0]   green_o,
  output logic [CH_W-1:0]   blue_o,
  output logic              conv_valid_o,
  input  logic [CH_W-1:0]   gray_i,
  input  logic              gray_valid_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [CH_W-1:0]   wr_data_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int N = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  seq_state_t        r_state;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic              r_wr_term;
  logic              r_rd_en;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [CH_W-1:0]   r_wr_data;
  logic              w_clr;
  logic              w_conv_valid;
  logic              w_wr_phase;

  assign w_clr      = rst | abort_i;
  assign w_wr_phase = (r_state == ST_RUN) || (r_state == ST_DRAIN);

  // r_wr_term marks the final write so completion works even when wr_cnt wraps at N = 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rd_cnt     <= '0;
      r_wr_cnt     <= '0;
      r_wr_term    <= 1'b0;
      r_rd_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else if (abort_i) begin
      r_state      <= ST_IDLE;
      r_rd_cnt     <= '0;
      r_wr_cnt     <= '0;
      r_wr_term    <= 1'b0;
      r_rd_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_wr_en      <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_wr_phase && gray_valid_i) begin
        r_wr_en   <= 1'b1;
        r_wr_data <= gray_i;
        r_wr_addr <= r_wr_cnt;
        r_wr_cnt  <= r_wr_cnt + ADDR_W'(1);
        if (r_wr_cnt == LAST_IDX) begin
          r_wr_term <= 1'b1;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state   <= ST_RUN;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_wr_term <= 1'b0;
            r_rd_en   <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (r_rd_cnt == LAST_IDX) begin
            r_state  <= ST_DRAIN;
            r_rd_cnt <= '0;
            r_rd_en  <= 1'b0;
          end else begin
            r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (r_wr_term) begin
            r_state      <= ST_DONE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_rd_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Converter strobe lines up with the read data returned by the source memory.
  valid_delay_line #(
    .DEPTH(SRC_RD_LAT)
  ) u_valid_dly (
    .clk  (clk),
    .i_clr(w_clr),
    .i_d  (r_rd_en),
    .o_q  (w_conv_valid)
  );

  assign rd_en_o      = r_rd_en;
  assign rd_addr_o    = r_rd_cnt;
  assign red_o        = get_channel(rd_rgb_i, R_LSB);
  assign green_o      = get_channel(rd_rgb_i, G_LSB);
  assign blue_o       = get_channel(rd_rgb_i, B_LSB);
  assign conv_valid_o = w_conv_valid;
  assign wr_en_o      = r_wr_en;
  assign wr_addr_o    = r_wr_addr;
  assign wr_data_o    = r_wr_data;
  assign busy_o       = r_busy;
  assign frame_done_o = r_frame_done;

endmodule
